// File: rtl/gamecontrol_pkg.sv
// rtl/gamecontrol_pkg.sv - shared types, constants and BCD helpers for gamecontrol_levels
package gamecontrol_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam logic [1:0] LVL_EASY   = 2'd0;
    localparam logic [1:0] LVL_MEDIUM = 2'd1;
    localparam logic [1:0] LVL_HARD   = 2'd2;
    localparam logic [1:0] LVL_EXPERT = 2'd3;

    // Fibonacci taps 8,6,5,4 as a mask over bits [7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int BCD_MAX_DIGITS = 8;

    // Saturating BCD +1 over the low 'digits' nibbles
    function automatic logic [31:0] bcd_inc(input logic [31:0] v, input int digits);
        logic [31:0] r;
        logic        all_nines;
        logic        carry;
        r         = v;
        all_nines = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits && v[4*i +: 4] != 4'd9) all_nines = 1'b0;
        end
        carry = ~all_nines;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits && carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Saturating BCD -1 over the low 'digits' nibbles
    function automatic logic [31:0] bcd_dec(input logic [31:0] v, input int digits);
        logic [31:0] r;
        logic        is_zero;
        logic        borrow;
        r       = v;
        is_zero = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits && v[4*i +: 4] != 4'd0) is_zero = 1'b0;
        end
        borrow = ~is_zero;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits && borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_lfsr.sv
// rtl/morse_lfsr.sv - free-running Fibonacci LFSR, advances every cycle out of reset
module morse_lfsr
    import gamecontrol_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = {value_q[WIDTH-2:0], ^(value_q & TAPS)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/gamecontrol_levels.sv
// rtl/gamecontrol_levels.sv - levelled game controller; optional STREAK_BONUS_EN streak bonus
module gamecontrol_levels
    import gamecontrol_pkg::*;
#(
    parameter int         NUM_W        = 4,
    parameter int         SCORE_DIGITS = 2,
    parameter int         MAX_ROUNDS   = 10,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      logged_in,
    input  logic [1:0]                level,
    input  logic                      game_start,
    input  logic                      load,
    input  logic [NUM_W-1:0]          user_input,
    input  logic                      timeout,
    input  logic                      logout,
    output logic                      reconfig,
    output logic                      enable,
    output logic [NUM_W-1:0]          number,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic                      correct,
    output logic [7:0]                round_cnt,
    output logic                      game_over,
    output logic                      logout_from_gamecontrol
);

    localparam int SW = 4 * SCORE_DIGITS;

    state_e           state_q, state_d;
    logic [1:0]       level_q, level_d;
    logic [NUM_W-1:0] number_q, number_d;
    logic [SW-1:0]    score_q, score_d;
    logic             correct_q, correct_d;
    logic [7:0]       round_q, round_d;
    logic             hit_q, hit_d;
    logic             reconfig_q, reconfig_d;
    logic             enable_q, enable_d;
    logic             game_over_q, game_over_d;
    logic             ack_q, ack_d;
`ifdef STREAK_BONUS_EN
    logic [1:0]       streak_q, streak_d;
`endif

    logic [7:0]       lfsr_value;
    logic [NUM_W-1:0] raw;
    logic [NUM_W-1:0] mapped;
    logic             lfsr_unused;

    morse_lfsr #(
        .WIDTH (8),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    assign raw         = lfsr_value[NUM_W-1:0];
    assign lfsr_unused = ^lfsr_value;

    always_comb begin
        mapped = raw;
        case (level_q)
            LVL_EASY:   mapped = raw & NUM_W'(3);
            LVL_MEDIUM: mapped = raw & NUM_W'(7);
            LVL_HARD:   if (raw >= NUM_W'(10)) mapped = raw - NUM_W'(10);
            default:    mapped = raw;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        number_d  = number_q;
        score_d   = score_q;
        correct_d = correct_q;
        round_d   = round_q;
        hit_d     = hit_q;
        ack_d     = 1'b0;
`ifdef STREAK_BONUS_EN
        streak_d  = streak_q;
`endif

        if (state_q != S_IDLE && logout) begin
            state_d = S_IDLE;
            ack_d   = 1'b1;
            score_d = '0;
`ifdef STREAK_BONUS_EN
            streak_d = 2'd0;
`endif
        end else if (state_q != S_IDLE && !logged_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (logged_in) state_d = S_READY;
                end
                S_READY, S_DONE: begin
                    if (game_start) begin
                        level_d   = level;
                        score_d   = '0;
                        round_d   = 8'd0;
                        correct_d = 1'b0;
                        hit_d     = 1'b0;
`ifdef STREAK_BONUS_EN
                        streak_d  = 2'd0;
`endif
                        state_d   = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    number_d = mapped;
                    state_d  = S_WAIT;
                end
                S_WAIT: begin
                    // load outranks a coincident timeout
                    if (load) begin
                        hit_d   = (user_input == number_q);
                        state_d = S_RESULT;
                    end else if (timeout) begin
                        hit_d   = 1'b0;
                        state_d = S_RESULT;
                    end
                end
                S_RESULT: begin
                    correct_d = hit_q;
                    round_d   = round_q + 8'd1;
                    if (hit_q) begin
`ifdef STREAK_BONUS_EN
                        if (streak_q[1]) begin
                            score_d = SW'(bcd_inc(bcd_inc(32'(score_q), SCORE_DIGITS), SCORE_DIGITS));
                        end else begin
                            score_d = SW'(bcd_inc(32'(score_q), SCORE_DIGITS));
                        end
                        if (streak_q != 2'd3) streak_d = streak_q + 2'd1;
`else
                        score_d = SW'(bcd_inc(32'(score_q), SCORE_DIGITS));
`endif
                    end else begin
                        if (level_q == LVL_EXPERT) begin
                            score_d = SW'(bcd_dec(32'(score_q), SCORE_DIGITS));
                        end
`ifdef STREAK_BONUS_EN
                        streak_d = 2'd0;
`endif
                    end
                    state_d = (round_q + 8'd1 == 8'(MAX_ROUNDS)) ? S_DONE : S_ISSUE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered copies of where the FSM is heading
        reconfig_d  = (state_d == S_ISSUE);
        enable_d    = (state_d == S_WAIT);
        game_over_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            level_q     <= 2'd0;
            number_q    <= '0;
            score_q     <= '0;
            correct_q   <= 1'b0;
            round_q     <= 8'd0;
            hit_q       <= 1'b0;
            reconfig_q  <= 1'b0;
            enable_q    <= 1'b0;
            game_over_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            number_q    <= number_d;
            score_q     <= score_d;
            correct_q   <= correct_d;
            round_q     <= round_d;
            hit_q       <= hit_d;
            reconfig_q  <= reconfig_d;
            enable_q    <= enable_d;
            game_over_q <= game_over_d;
            ack_q       <= ack_d;
        end
    end

`ifdef STREAK_BONUS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= 2'd0;
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

    assign reconfig                = reconfig_q;
    assign enable                  = enable_q;
    assign number                  = number_q;
    assign score                   = score_q;
    assign correct                 = correct_q;
    assign round_cnt               = round_q;
    assign game_over               = game_over_q;
    assign logout_from_gamecontrol = ack_q;

endmodule

// File: tb/tb_gamecontrol_levels.sv
// tb/tb_gamecontrol_levels.sv - self-checking bench for gamecontrol_levels
module tb_gamecontrol_levels;

    localparam int NUM_W = 4;
    localparam int SD    = 2;
    localparam int MR    = 10;
    localparam int SMAX  = 99;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       logged_in = 1'b1, game_start = 1'b0, load = 1'b0, timeout = 1'b0, logout = 1'b0;
    logic [1:0] level = 2'd0;
    logic [3:0] user_input = 4'd0;
    logic       reconfig, enable, correct, game_over, lo_ack;
    logic [3:0] number;
    logic [7:0] score, round_cnt;

    logic       s_logged_in = 1'b1, s_game_start = 1'b0, s_load = 1'b0, s_timeout = 1'b0, s_logout = 1'b0;
    logic [1:0] s_level = 2'd0;
    logic [3:0] s_user_input = 4'd0;
    logic       s_reconfig, s_enable, s_correct, s_game_over, s_ack;
    logic [3:0] s_number;
    logic [3:0] s_score;
    logic [7:0] s_round_cnt;

    gamecontrol_levels #(.NUM_W(NUM_W), .SCORE_DIGITS(SD), .MAX_ROUNDS(MR), .LFSR_SEED(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .logged_in(logged_in), .level(level), .game_start(game_start),
        .load(load), .user_input(user_input), .timeout(timeout), .logout(logout),
        .reconfig(reconfig), .enable(enable), .number(number), .score(score), .correct(correct),
        .round_cnt(round_cnt), .game_over(game_over), .logout_from_gamecontrol(lo_ack)
    );

    gamecontrol_levels #(.NUM_W(4), .SCORE_DIGITS(1), .MAX_ROUNDS(12), .LFSR_SEED(8'hA5)) u_sat (
        .clk(clk), .rst(rst), .logged_in(s_logged_in), .level(s_level), .game_start(s_game_start),
        .load(s_load), .user_input(s_user_input), .timeout(s_timeout), .logout(s_logout),
        .reconfig(s_reconfig), .enable(s_enable), .number(s_number), .score(s_score), .correct(s_correct),
        .round_cnt(s_round_cnt), .game_over(s_game_over), .logout_from_gamecontrol(s_ack)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int rc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_num(input logic [7:0] lf, input int lvl);
        int r;
        r = int'(lf) % 16;
        case (lvl)
            0:       return r % 4;
            1:       return r % 8;
            2:       return r % 10;
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int digits);
        logic [31:0] b;
        int          x;
        b = 32'd0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            b = b | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return b;
    endfunction

    // Reference model: phase 0 idle,1 ready,2 issue,3 wait,4 result,5 done; score kept as an integer
    int         m_ph, m_score, m_round, m_num, m_lvl, m_streak, m_inc;
    logic       m_correct, m_hit, m_ack;
    logic [7:0] m_lfsr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = 0; m_score = 0; m_round = 0; m_num = 0; m_lvl = 0; m_streak = 0;
            m_correct = 1'b0; m_hit = 1'b0; m_ack = 1'b0; m_lfsr = 8'hA5;
        end else begin
            m_ack = 1'b0;
            if (m_ph != 0 && logout) begin
                m_ph = 0; m_ack = 1'b1; m_score = 0; m_streak = 0;
            end else if (m_ph != 0 && !logged_in) begin
                m_ph = 0;
            end else begin
                case (m_ph)
                    0: if (logged_in) m_ph = 1;
                    1, 5: if (game_start) begin
                        m_lvl = int'(level); m_score = 0; m_round = 0; m_correct = 1'b0;
                        m_streak = 0; m_ph = 2;
                    end
                    2: begin m_num = map_num(m_lfsr, m_lvl); m_ph = 3; end
                    3: if (load) begin
                        m_hit = (int'(user_input) == m_num); m_ph = 4;
                    end else if (timeout) begin
                        m_hit = 1'b0; m_ph = 4;
                    end
                    4: begin
                        m_correct = m_hit;
                        m_round++;
                        if (m_hit) begin
                            m_inc = 1;
`ifdef STREAK_BONUS_EN
                            if (m_streak >= 2) m_inc = 2;
`endif
                            m_score = (m_score + m_inc > SMAX) ? SMAX : m_score + m_inc;
                            m_streak++;
                        end else begin
                            if (m_lvl == 3 && m_score > 0) m_score--;
                            m_streak = 0;
                        end
                        m_ph = (m_round == MR) ? 5 : 2;
                    end
                    default: m_ph = 0;
                endcase
            end
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("number",    32'(number),    32'(m_num));
            chk("score",     32'(score),     to_bcd(m_score, SD));
            chk("correct",   32'(correct),   32'(m_correct));
            chk("round_cnt", 32'(round_cnt), 32'(m_round));
            chk("game_over", 32'(game_over), 32'(m_ph == 5));
            chk("enable",    32'(enable),    32'(m_ph == 3));
            chk("reconfig",  32'(reconfig),  32'(m_ph == 2));
            chk("logout_ack", 32'(lo_ack),   32'(m_ack));
            if (reconfig) rc_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en();
        int n;
        n = 0;
        while (!enable && n < 30) begin
            tick();
            n++;
        end
        if (!enable) chk("wait_enable_timeout", 32'(enable), 32'd1);
    endtask

    // mode: 0 timeout, 1 correct load, 2 correct load + timeout, 3 wrong load
    task automatic play_round(input int mode);
        wait_en();
        case (mode)
            0: timeout = 1'b1;
            1: begin load = 1'b1; user_input = number; end
            2: begin load = 1'b1; user_input = number; timeout = 1'b1; end
            default: begin load = 1'b1; user_input = number ^ 4'd1; end
        endcase
        tick();
        load = 1'b0; timeout = 1'b0;
        tick();
    endtask

    task automatic start_game(input logic [1:0] lvl);
        level = lvl;
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
    endtask

    int exp_seq[7];
    int rc_base;
    int s_exp;
    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_number", 32'(number), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("lfsr_seed", 32'(u_dut.lfsr_value), 32'hA5);
        tick();

        // all-correct game at easy level
        start_game(2'd0);
        for (int r = 0; r < MR; r++) begin
            wait_en();
            chk("num_le3", 32'(number <= 4'd3), 32'd1);
            play_round(1);
        end
        chk("t2_score", 32'(score), 32'h10);
        chk("t2_round", 32'(round_cnt), 32'd10);
        chk("t2_game_over", 32'(game_over), 32'd1);
        chk("t2_correct", 32'(correct), 32'd1);

        // expert level: one hit then three timeouts; level change mid-game ignored
        start_game(2'd3);
        level = 2'd1;
        rc_base = rc_cnt;
        play_round(1);
        chk("t3_score_r1", 32'(score), 32'h01);
        for (int r = 0; r < 3; r++) begin
            play_round(0);
            chk("t3_score_miss", 32'(score), 32'h00);
        end
        chk("t3_correct", 32'(correct), 32'd0);
        chk("t3_reconfig_pulses", 32'(rc_cnt - rc_base), 32'd4);

        // load and timeout together count as a hit
        play_round(2);
        chk("t4_score", 32'(score), 32'h01);
        chk("t4_correct", 32'(correct), 32'd1);

        // logout with a simultaneous correct load
        wait_en();
        logout = 1'b1; load = 1'b1; user_input = number;
        tick();
        logout = 1'b0; load = 1'b0;
        chk("t5_ack", 32'(lo_ack), 32'd1);
        chk("t5_enable", 32'(enable), 32'd0);
        chk("t5_score", 32'(score), 32'd0);
        tick();
        chk("t5_ack_once", 32'(lo_ack), 32'd0);

        // logged_in dropping mid-round: back to idle without acknowledge
        start_game(2'd2);
        wait_en();
        logged_in = 1'b0;
        tick();
        chk("drop_enable", 32'(enable), 32'd0);
        chk("drop_ack", 32'(lo_ack), 32'd0);
        logged_in = 1'b1;
        tick();
        tick();

        // streak sequence at medium level: five hits, a wrong answer, a hit
`ifdef STREAK_BONUS_EN
        exp_seq = '{1, 2, 4, 6, 8, 8, 9};
`else
        exp_seq = '{1, 2, 3, 4, 5, 5, 6};
`endif
        start_game(2'd1);
        for (int r = 0; r < 7; r++) begin
            play_round(r == 5 ? 3 : 1);
            chk("t6_score", 32'(score), to_bcd(exp_seq[r], SD));
        end

        // one-digit score saturation over 12 rounds on the second instance
        s_level = 2'd1;
        s_game_start = 1'b1;
        tick();
        s_game_start = 1'b0;
        s_exp = 0;
        for (int r = 0; r < 12; r++) begin
            n = 0;
            while (!s_enable && n < 30) begin
                tick();
                n++;
            end
            if (!s_enable) chk("sat_wait_timeout", 32'(s_enable), 32'd1);
            s_load = 1'b1;
            s_user_input = s_number;
            tick();
            s_load = 1'b0;
            tick();
`ifdef STREAK_BONUS_EN
            s_exp = s_exp + ((r >= 2) ? 2 : 1);
`else
            s_exp = s_exp + 1;
`endif
            if (s_exp > 9) s_exp = 9;
            chk("sat_score", 32'(s_score), 32'(s_exp));
        end
        chk("sat_score_final", 32'(s_score), 32'd9);
        chk("sat_round", 32'(s_round_cnt), 32'd12);
        chk("sat_game_over", 32'(s_game_over), 32'd1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
